// File: rtl/ws2812_rx_if.sv
// Bus bundle for the WS2812 receiver: serial line in, decoded pixel stream and
// frame status out, plus the FSM state for observation.
interface ws2812_rx_if;
   logic        i_din;
   logic [23:0] o_pixel;
   logic        o_valid;
   logic        o_latch;
   logic        o_err;
   logic [15:0] o_frame_len;
   logic        o_dout;
   logic [1:0]  dbg_state;

   // Status outputs are single-cycle pulses with no back-pressure. The receiver
   // has no ready input, so a consumer must sample them every cycle.
   modport slave (
      input  i_din,
      output o_pixel, o_valid, o_latch, o_err, o_frame_len, o_dout, dbg_state
   );

   modport master (
      output i_din,
      input  o_pixel, o_valid, o_latch, o_err, o_frame_len, o_dout, dbg_state
   );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 serial line decoder: recovers 24-bit GRB pixels, frame latches and errors.
// Optional macro WS2812_RX_PASSTHRU_EN regenerates the line downstream after pixel 1.
module ws2812_rx #(
   parameter int HIGH_THRESH = 30,
   parameter int MAX_HIGH    = 60,
   parameter int RESET_TICKS = 2500
) (
   input  logic        i_clk,
   input  logic        i_rst,
   ws2812_rx_if.slave  bus
);

   localparam int HW = $clog2(MAX_HIGH + 2);
   localparam int LW = $clog2(RESET_TICKS + 1);
   localparam logic [HW-1:0] HI_MAX    = HW'(MAX_HIGH);
   localparam logic [HW-1:0] HI_SAT    = HW'(MAX_HIGH + 1);
   localparam logic [HW-1:0] HI_THRESH = HW'(HIGH_THRESH);
   localparam logic [LW-1:0] LO_SAT    = LW'(RESET_TICKS);
   localparam logic [LW-1:0] LO_LAST   = LW'(RESET_TICKS - 1);

   typedef enum logic [1:0] {
      WAIT_GAP = 2'd0,
      RUN      = 2'd1,
      ERR      = 2'd2
   } state_t;

   logic          din_m, din_s, din_q;
   logic [HW-1:0] hi_cnt;
   logic [LW-1:0] lo_cnt;

   state_t        state_q, state_d;
   logic [22:0]   shift_q, shift_d;
   logic [4:0]    bit_idx_q, bit_idx_d;
   logic [15:0]   pix_cnt_q, pix_cnt_d;
   logic [23:0]   pixel_q, pixel_d;
   logic [15:0]   frame_len_q, frame_len_d;
   logic          valid_q, valid_d;
   logic          latch_q, latch_d;
   logic          err_q, err_d;

   logic          fall;
   logic          gap_hit;
   logic          overflow;
   logic          bit_val;

   // Synchronizer, edge history and the high/low width counters.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         din_m  <= 1'b0;
         din_s  <= 1'b0;
         din_q  <= 1'b0;
         hi_cnt <= '0;
         lo_cnt <= '0;
      end else begin
         din_m <= bus.i_din;
         din_s <= din_m;
         din_q <= din_s;
         if (din_s) begin
            lo_cnt <= '0;
            if (hi_cnt != HI_SAT) hi_cnt <= hi_cnt + 1'b1;
         end else begin
            hi_cnt <= '0;
            if (lo_cnt != LO_SAT) lo_cnt <= lo_cnt + 1'b1;
         end
      end
   end

   // hi_cnt still holds the finished pulse width in the cycle the fall is seen.
   assign fall     = din_q & ~din_s;
   assign gap_hit  = ~din_s && (lo_cnt == LO_LAST);
   assign overflow = din_s && (hi_cnt == HI_MAX);
   assign bit_val  = (hi_cnt >= HI_THRESH);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      pix_cnt_d   = pix_cnt_q;
      pixel_d     = pixel_q;
      frame_len_d = frame_len_q;
      valid_d     = 1'b0;
      latch_d     = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         WAIT_GAP: begin
            if (gap_hit) begin
               state_d   = RUN;
               bit_idx_d = '0;
               pix_cnt_d = '0;
            end
         end

         RUN: begin
            if (overflow) begin
               err_d     = 1'b1;
               bit_idx_d = '0;
               state_d   = ERR;
            end else if (fall && (hi_cnt <= HI_MAX)) begin
               shift_d = {shift_q[21:0], bit_val};
               if (bit_idx_q == 5'd23) begin
                  pixel_d   = {shift_q, bit_val};
                  valid_d   = 1'b1;
                  bit_idx_d = '0;
                  if (pix_cnt_q != 16'hFFFF) pix_cnt_d = pix_cnt_q + 16'd1;
               end else begin
                  bit_idx_d = bit_idx_q + 5'd1;
               end
            end else if (gap_hit) begin
               // A gap inside a pixel ends the frame and flags the truncation.
               latch_d     = 1'b1;
               err_d       = (bit_idx_q != 5'd0);
               frame_len_d = pix_cnt_q;
               pix_cnt_d   = '0;
               bit_idx_d   = '0;
            end
         end

         ERR: begin
            if (gap_hit) begin
               latch_d     = 1'b1;
               frame_len_d = pix_cnt_q;
               pix_cnt_d   = '0;
               bit_idx_d   = '0;
               state_d     = RUN;
            end
         end

         default: begin
            state_d = WAIT_GAP;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= WAIT_GAP;
         shift_q     <= '0;
         bit_idx_q   <= '0;
         pix_cnt_q   <= '0;
         pixel_q     <= '0;
         frame_len_q <= '0;
         valid_q     <= 1'b0;
         latch_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         pix_cnt_q   <= pix_cnt_d;
         pixel_q     <= pixel_d;
         frame_len_q <= frame_len_d;
         valid_q     <= valid_d;
         latch_q     <= latch_d;
         err_q       <= err_d;
      end
   end

   assign bus.o_pixel     = pixel_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_latch     = latch_q;
   assign bus.o_err       = err_q;
   assign bus.o_frame_len = frame_len_q;
   assign bus.dbg_state   = state_q;

`ifdef WS2812_RX_PASSTHRU_EN
   // Pixel 1 is consumed here; everything after it is forwarded until the gap.
   assign bus.o_dout = (state_q == RUN) && (pix_cnt_q != 16'd0) && din_s;
`else
   assign bus.o_dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: table vectors, directed corner sequences and random frames
// checked against a transaction-level model of the line protocol.
module tb_ws2812_rx;

   localparam int HIGH_THRESH = 30;
   localparam int MAX_HIGH    = 60;
   localparam int RESET_TICKS = 2500;
   localparam int BIT_PERIOD  = 62;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ws2812_rx_if bus ();

   ws2812_rx #(
      .HIGH_THRESH (HIGH_THRESH),
      .MAX_HIGH    (MAX_HIGH),
      .RESET_TICKS (RESET_TICKS)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: works on whole bits and gaps, not on clock cycles.
   int          m_state;  // 0 waiting for first gap, 1 running, 2 error
   int          m_acc, m_nbits, m_pixcnt;
   int          exp_err, exp_err_latch;
   logic [23:0] exp_q[$];
   logic [15:0] exp_len_q[$];

   // Observed DUT events.
   logic [23:0] act_pix_q[$];
   logic [15:0] act_len_q[$];
   int          act_err, act_err_latch;
   int          dout_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_state = 0; m_acc = 0; m_nbits = 0; m_pixcnt = 0;
   endfunction

   function automatic void model_bit(input int w);
      if (m_state != 1) return;
      if (w > MAX_HIGH) begin
         m_state = 2; m_nbits = 0; m_acc = 0; exp_err++;
         return;
      end
      m_acc = m_acc * 2 + ((w >= HIGH_THRESH) ? 1 : 0);
      m_nbits++;
      if (m_nbits == 24) begin
         exp_q.push_back(m_acc[23:0]);
         m_acc = 0; m_nbits = 0;
         if (m_pixcnt < 65535) m_pixcnt++;
      end
   endfunction

   function automatic void model_gap();
      if (m_state == 0) begin
         m_state = 1;
         return;
      end
      exp_len_q.push_back(16'(m_pixcnt));
      if (m_nbits != 0) begin
         exp_err++; exp_err_latch++;
      end
      m_state = 1; m_nbits = 0; m_acc = 0; m_pixcnt = 0;
   endfunction

   function automatic int high_sum(input logic [23:0] p, input int t0h, input int t1h);
      int s = 0;
      for (int i = 0; i < 24; i++) s += p[i] ? t1h : t0h;
      return s;
   endfunction

   // Driver tasks: all are entered and left on a falling clock edge.
   task automatic hold(input logic v, input int n);
      bus.i_din = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input int hi, input int lo);
      hold(1'b1, hi);
      hold(1'b0, lo);
      model_bit(hi);
   endtask

   task automatic send_pixel(input logic [23:0] p, input int t0h, input int t1h);
      for (int i = 23; i >= 0; i--) begin
         if (p[i]) send_bit(t1h, BIT_PERIOD - t1h);
         else      send_bit(t0h, BIT_PERIOD - t0h);
      end
   endtask

   task automatic send_gap();
      hold(1'b0, RESET_TICKS);
      model_gap();
   endtask

   task automatic rand_bit();
      int sel, hi;
      sel = $urandom_range(0, 5);
      case (sel)
         0:       hi = 1;
         1:       hi = HIGH_THRESH - 1;
         2:       hi = HIGH_THRESH;
         3:       hi = MAX_HIGH;
         default: hi = $urandom_range(1, MAX_HIGH);
      endcase
      send_bit(hi, $urandom_range(2, 40));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      hold(1'b0, 3);
      rst = 1'b0;
      model_reset();
   endtask

   // Monitor samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.o_valid) act_pix_q.push_back(bus.o_pixel);
         if (bus.o_latch) act_len_q.push_back(bus.o_frame_len);
         if (bus.o_err) act_err++;
         if (bus.o_err && bus.o_latch) act_err_latch++;
         if (bus.o_dout) dout_cnt++;
         if (bus.o_valid && bus.o_latch) begin
            n_errors++;
            $display("FAIL valid_with_latch: got valid=1 latch=1 expected not both");
         end
`ifndef WS2812_RX_PASSTHRU_EN
         if (bus.o_dout !== 1'b0) begin
            n_errors++;
            $display("FAIL dout_tied: got %b expected 0", bus.o_dout);
         end
`endif
      end
   end

   // Scoreboard: drain observed events against the model's expectations.
   task automatic checkpoint(input string tag);
      logic [23:0] a, e;
      logic [15:0] al, el;
      repeat (5) @(negedge clk);
      check({tag, " n_valid"}, act_pix_q.size(), exp_q.size());
      while (act_pix_q.size() > 0 && exp_q.size() > 0) begin
         a = act_pix_q.pop_front();
         e = exp_q.pop_front();
         check({tag, " pixel"}, a, e);
      end
      check({tag, " n_latch"}, act_len_q.size(), exp_len_q.size());
      while (act_len_q.size() > 0 && exp_len_q.size() > 0) begin
         al = act_len_q.pop_front();
         el = exp_len_q.pop_front();
         check({tag, " frame_len"}, al, el);
      end
      check({tag, " n_err"}, act_err, exp_err);
      check({tag, " n_err_with_latch"}, act_err_latch, exp_err_latch);
      act_pix_q.delete(); exp_q.delete(); act_len_q.delete(); exp_len_q.delete();
      act_err = 0; exp_err = 0; act_err_latch = 0; exp_err_latch = 0;
   endtask

   typedef struct {
      logic [23:0] bits;
      int          t0h;
      int          t1h;
      logic [23:0] exp_pixel;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int lat, pos, exp_dout;
      logic [23:0] a;

      vecs[0] = '{24'hFF0080, 20, 40, 24'hFF0080};
      vecs[1] = '{24'hA5A5A5, 29, 30, 24'hA5A5A5};
      vecs[2] = '{24'hFFFFFF,  1, 29, 24'h000000};
      vecs[3] = '{24'h5A5A5A,  1, 60, 24'h5A5A5A};
      vecs[4] = '{24'h3C3C3C, 30, 30, 24'hFFFFFF};

      bus.i_din = 1'b0;
      model_reset();
      exp_err = 0; exp_err_latch = 0; act_err = 0; act_err_latch = 0; dout_cnt = 0;

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst pixel", bus.o_pixel, 24'h0);
      check("rst valid", bus.o_valid, 1'b0);
      check("rst latch", bus.o_latch, 1'b0);
      check("rst err", bus.o_err, 1'b0);
      check("rst frame_len", bus.o_frame_len, 16'h0);
      check("rst dout", bus.o_dout, 1'b0);
      check("rst state", bus.dbg_state, 2'd0);
      rst = 1'b0;

      // First gap arms the receiver without a latch.
      send_gap();
      checkpoint("wait_gap");
      check("state after first gap", bus.dbg_state, 2'd1);

      // Table vectors: threshold and max-width boundaries.
      for (int i = 0; i < 5; i++) begin
         send_pixel(vecs[i].bits, vecs[i].t0h, vecs[i].t1h);
         repeat (5) @(negedge clk);
         check("tbl n_valid", act_pix_q.size(), 1);
         if (act_pix_q.size() > 0) begin
            a = act_pix_q.pop_front();
            check("tbl pixel", a, vecs[i].exp_pixel);
         end
         act_pix_q.delete(); exp_q.delete();
      end
      send_gap();
      checkpoint("table_frame");

      // Three pixels then latch; passthrough window measured on pixels 1 and 2.
      dout_cnt = 0;
      send_pixel(24'h000001, 20, 40);
      check("dout pixel1", dout_cnt, 0);
      dout_cnt = 0;
      send_pixel(24'h800000, 20, 40);
      repeat (4) @(negedge clk);
`ifdef WS2812_RX_PASSTHRU_EN
      exp_dout = high_sum(24'h800000, 20, 40);
`else
      exp_dout = 0;
`endif
      check("dout pixel2", dout_cnt, exp_dout);
      send_pixel(24'hABCDEF, 20, 40);
      send_gap();
      checkpoint("three_px");

      // Valid latency measured from the final falling edge of a pixel.
      for (int i = 0; i < 23; i++) send_bit(40, 22);
      hold(1'b1, 40);
      bus.i_din = 1'b0;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.o_valid && lat == 0) lat = k;
      end
      model_bit(40);
      hold(1'b0, 16);
      check("valid latency", lat, 3);
      send_gap();
      checkpoint("latency");

      // Overlong high: error after 2 sync cycles plus MAX_HIGH+1 counts.
      send_pixel(24'hC3C3C3, 20, 40);
      for (int i = 0; i < 5; i++) send_bit(40, 22);
      bus.i_din = 1'b1;
      pos = 0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (bus.o_err && pos == 0) pos = k;
      end
      model_bit(70);
      hold(1'b0, 22);
      check("overflow err cycle", pos, MAX_HIGH + 3);
      check("state in err", bus.dbg_state, 2'd2);
      for (int i = 0; i < 30; i++) send_bit(40, 22);
      send_gap();
      checkpoint("overflow");
      check("state after err gap", bus.dbg_state, 2'd1);
      send_pixel(24'h123456, 20, 40);
      checkpoint("after_err");
      send_gap();
      checkpoint("after_err_gap");

      // Partial pixel cut by a gap.
      for (int i = 0; i < 12; i++) send_bit(($urandom_range(0, 1) != 0) ? 40 : 20, 22);
      send_gap();
      checkpoint("partial_gap");

      // Reset mid-frame: bits ignored until a fresh gap, which itself does not latch.
      send_pixel(24'h00FF00, 20, 40);
      send_gap();
      checkpoint("pre_reset_frame");
      for (int i = 0; i < 10; i++) send_bit(40, 22);
      do_reset();
      check("frame_len after reset", bus.o_frame_len, 16'h0);
      check("state after reset", bus.dbg_state, 2'd0);
      send_pixel(24'h0F0F0F, 20, 40);
      send_gap();
      checkpoint("reset_no_gap");
      check("frame_len after wait gap", bus.o_frame_len, 16'h0);
      send_pixel(24'h0F0F0F, 20, 40);
      checkpoint("reset_recover");
      send_gap();
      checkpoint("reset_recover_gap");

      // Random frames with boundary-biased widths and occasional partial tails.
      for (int f = 0; f < 5; f++) begin
         int npix;
         npix = $urandom_range(1, 3);
         for (int p = 0; p < npix; p++)
            for (int b = 0; b < 24; b++) rand_bit();
         if ($urandom_range(0, 2) == 0) begin
            int nb;
            nb = $urandom_range(1, 23);
            for (int b = 0; b < nb; b++) rand_bit();
         end
         send_gap();
         checkpoint("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL provide parameter HIGH_THRESH, default 30, minimum high width in clocks that decodes a bit as 1 (T0H 20 / T1H 40 clocks at 50 MHz).
REQ-002 SHALL provide parameter MAX_HIGH, default 60, largest legal high width in clocks.
REQ-003 SHALL provide parameter RESET_TICKS, default 2500, line-low clocks that constitute a latch/reset gap (50 us at 50 MHz).
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_din  input  1  WS2812 serial line, asynchronous to i_clk.
REQ-007 o_pixel  output  24  last complete pixel, GRB, first received bit in [23].
REQ-008 o_valid  output  1  one-cycle pulse when o_pixel updates.
REQ-009 o_latch  output  1  one-cycle pulse when a reset gap is detected.
REQ-010 o_err  output  1  one-cycle pulse on a protocol error.
REQ-011 o_frame_len  output  16  pixels received in the last frame that ended with a latch.
REQ-012 o_dout  output  1  regenerated downstream line (see Configuration).

Function
REQ-013 i_din SHALL pass through a 2-flop synchronizer (din_s); all timing is measured on din_s.
REQ-014 High counter: +1 per cycle din_s=1, saturates at MAX_HIGH+1, clears on falling edge.
REQ-015 Low counter: +1 per cycle din_s=0, saturates at RESET_TICKS, clears on rising edge.
REQ-016 States: WAIT_GAP (after reset), RUN, ERR.
REQ-017 WAIT_GAP -> RUN when the low counter reaches RESET_TICKS; bits are ignored in WAIT_GAP.
REQ-018 In RUN, each falling edge with high width <= MAX_HIGH SHALL shift in bit = (width >= HIGH_THRESH), MSB first, and increment a 0..23 bit index.
REQ-019 On the 24th bit: o_pixel loads, o_valid pulses, bit index returns to 0, and the frame pixel count increments (saturating at 65535).
REQ-020 Output latency: o_valid SHALL assert on the 3rd rising i_clk edge after the i_din fall is first sampled.
REQ-021 High counter reaching MAX_HIGH+1 in RUN: o_err pulses once, the partial pixel is discarded, and the state goes to ERR.
REQ-022 ERR -> RUN on reset gap; no bits are accepted in ERR.
REQ-023 Reset gap in RUN or ERR: o_latch pulses once per gap, o_frame_len <= pixel count, pixel count and bit index clear.
REQ-024 Gap with bit index != 0: o_err and o_latch pulse in the same cycle, and the partial pixel is discarded.
REQ-025 Gap reached in WAIT_GAP: no o_latch pulse and o_frame_len unchanged.
REQ-026 o_valid and o_latch never assert in the same cycle, since a gap requires a line held low.

Reset
REQ-027 On i_rst: o_pixel=0, o_valid=0, o_latch=0, o_err=0, o_frame_len=0, o_dout=0, synchronizer flops=0, counters=0, state=WAIT_GAP.
REQ-028 Reset asserted mid-frame SHALL discard the partial pixel; after release the block needs a full RESET_TICKS gap before accepting bits.

Configuration
REQ-029 Macro WS2812_RX_PASSTHRU_EN defined: o_dout = din_s while in RUN with frame pixel count >= 1, else 0; the gate opens at the falling edge completing pixel 1 and closes on gap.
REQ-030 Macro WS2812_RX_PASSTHRU_EN undefined: o_dout tied to 0 and the gating logic is absent.

Verification
REQ-031 Idle low 2500 clocks, then 24 bits 0xFF0080 (1=40 high/22 low, 0=20 high/42 low) -> one o_valid, o_pixel=0xFF0080, no o_err.
REQ-032 3 pixels (0x000001, 0x800000, 0xABCDEF), then 2500 low -> three o_valid with those values, then o_latch, o_frame_len=3.
REQ-033 Bit with 70-clock high mid-pixel -> o_err at high-count 61; further bits ignored until 2500-low gap; next pixel 0x123456 decodes correctly.
REQ-034 12 bits then 2500 low -> o_err and o_latch in the same cycle, no o_valid, o_frame_len=0.
REQ-035 i_rst pulsed after 10 bits, then 24 bits without a gap -> no o_valid; after a gap plus 24 bits 0x0F0F0F -> o_valid with 0x0F0F0F.
REQ-036 Passthrough build, 2 pixels -> o_dout stays 0 for pixel 1 and replicates din_s bits of pixel 2; non-passthrough build -> o_dout constant 0.
